// File: rtl/count_sequencer.sv
// Sequencer for an external 8-bit counter: clears it, paces its enable with a
// prescaler, and stops on a latched terminal count (one-shot or periodic).
module count_sequencer (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Mode,
  input  logic [7:0] Limit,
  input  logic [3:0] Presc,
  input  logic [7:0] CntQ,
  output logic       CntEn,
  output logic       CntClr,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_CLEAR = 3'b001,
    S_RUN   = 3'b010,
    S_HOLD  = 3'b011,
    S_DONE  = 3'b100
  } state_t;

  state_t     st, st_nxt;
  logic [3:0] psc, psc_nxt;
  logic       mode_q;
  logic [7:0] lim_q;
  logic [3:0] presc_q;
  logic       at_term, tick;

  assign at_term = (CntQ == lim_q);
  assign tick    = (psc == presc_q);

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      st      <= S_IDLE;
      psc     <= 4'd0;
      mode_q  <= 1'b0;
      lim_q   <= 8'd0;
      presc_q <= 4'd0;
    end else begin
      st  <= st_nxt;
      psc <= psc_nxt;
      // Run parameters are captured only when leaving IDLE; periodic restarts reuse them.
      if (st == S_IDLE && st_nxt == S_CLEAR) begin
        mode_q  <= Mode;
        lim_q   <= Limit;
        presc_q <= Presc;
      end
    end
  end

  always_comb begin
    st_nxt  = st;
    psc_nxt = psc;
    CntEn   = 1'b0;
    case (st)
      S_IDLE:  if (Start && !Stop) st_nxt = S_CLEAR;
      S_CLEAR: begin
        psc_nxt = 4'd0;
        st_nxt  = Stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        // Stop wins over terminal detection and suppresses the tick, so the
        // frozen prescale value replays that tick on resume.
        if (Stop)         st_nxt = S_HOLD;
        else if (at_term) st_nxt = S_DONE;
        else begin
          CntEn   = tick;
          psc_nxt = tick ? 4'd0 : psc + 4'd1;
        end
      end
      S_HOLD: begin
        if (Stop)       st_nxt = S_IDLE;
        else if (Start) st_nxt = S_RUN;
      end
      S_DONE: begin
        if (Stop)        st_nxt = S_IDLE;
        else if (mode_q) st_nxt = S_CLEAR;
        else             st_nxt = S_IDLE;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  assign CntClr = (st != S_CLEAR);
  assign Busy   = (st != S_IDLE);
  assign Done   = (st == S_DONE);
  assign State  = st;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboarded bench: a counter model sits on CntEn/CntClr, runs push their
// expected latency/pulses/final count, and every Done pops one entry.
module tb_count_sequencer;

  logic       Clk = 1'b0;
  logic       Clr = 1'b0;
  logic       Start = 1'b0, Stop = 1'b0, Mode = 1'b0;
  logic [7:0] Limit = 8'd0;
  logic [3:0] Presc = 4'd0;
  logic [7:0] CntQ;
  logic       CntEn, CntClr, Busy, Done;
  logic [2:0] State;

  count_sequencer dut (
    .Clk(Clk), .Clr(Clr), .Start(Start), .Stop(Stop), .Mode(Mode),
    .Limit(Limit), .Presc(Presc), .CntQ(CntQ), .CntEn(CntEn),
    .CntClr(CntClr), .Busy(Busy), .Done(Done), .State(State)
  );

  always #5 Clk = ~Clk;

  // external counter being sequenced
  logic [7:0] cnt = 8'd0;
  always @(posedge Clk) begin
    if (!CntClr)    cnt <= 8'd0;
    else if (CntEn) cnt <= cnt + 8'd1;
  end
  assign CntQ = cnt;

  typedef struct {
    int lat;     // cycles CLEAR->DONE, negative = not checked
    int pulses;
    int q;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // monitor
  int cyc = 0, clr_cyc = 0, pulses = 0;
  always @(negedge Clk) begin
    exp_t e;
    cyc++;
    if (State == 3'd1) begin
      clr_cyc = cyc;
      pulses  = 0;
    end
    if (CntEn) pulses++;
    if (Done) begin
      if (sb.size() == 0) chk("spurious_done", int'(Done), 0);
      else begin
        e = sb.pop_front();
        if (e.lat >= 0) chk("done_latency", cyc - clr_cyc, e.lat);
        chk("cnten_pulses", pulses, e.pulses);
        chk("cntq_at_done", int'(CntQ), e.q);
      end
    end
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic start_run(input logic m, input logic [7:0] l, input logic [3:0] p);
    step();
    Mode = m; Limit = l; Presc = p; Start = 1'b1;
    step();
    Start = 1'b0;
    // scramble parameters: the DUT must use its latched copies
    Mode = ~m; Limit = ~l; Presc = ~p;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (State != 3'd0 && n < budget) begin step(); n++; end
    if (State != 3'd0) chk(tag, int'(State), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"},  int'(State),  0);
    chk({tag, "_cnten"},  int'(CntEn),  0);
    chk({tag, "_cntclr"}, int'(CntClr), 1);
    chk({tag, "_busy"},   int'(Busy),   0);
    chk({tag, "_done"},   int'(Done),   0);
  endtask

  initial begin
    int n;
    #12;
    check_reset_outputs("reset");
    Clr = 1'b1;
    step();

    // one-shot Limit=3 Presc=0
    sb.push_back('{5, 3, 3});
    start_run(1'b0, 8'd3, 4'd0);
    wait_idle("t033_timeout", 50);
    chk("t033_cntq", int'(CntQ), 3);

    // Presc=1: a tick every other cycle
    sb.push_back('{8, 3, 3});
    start_run(1'b0, 8'd3, 4'd1);
    wait_idle("t034_timeout", 50);

    // Limit=0: terminal on first RUN cycle
    sb.push_back('{2, 0, 0});
    start_run(1'b0, 8'd0, 4'd5);
    wait_idle("t037_timeout", 50);

    // Start+Stop together in IDLE is Stop
    step();
    Start = 1'b1; Stop = 1'b1;
    step(); step(); step();
    chk("start_stop_idle", int'(State), 0);
    Start = 1'b0; Stop = 1'b0;

    // periodic Limit=2: three Done pulses, then Stop during DONE
    for (int i = 0; i < 3; i++) sb.push_back('{4, 2, 2});
    start_run(1'b1, 8'd2, 4'd0);
    n = 0;
    for (int k = 0; k < 100 && n < 3; k++) begin
      if (State == 3'd4) n++;
      if (n < 3) step();
    end
    chk("t035_done_count", n, 3);
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    chk("t035_stop_in_done", int'(State), 0);

    // pause at CntQ=1, hold four cycles, resume
    sb.push_back('{-1, 5, 5});
    start_run(1'b0, 8'd5, 4'd0);
    n = 0;
    while (CntQ != 8'd1 && n < 20) begin step(); n++; end
    chk("t036_reach_q1", int'(CntQ), 1);
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t036_hold_state", int'(State), 3);
      chk("t036_hold_cnten", int'(CntEn), 0);
      step();
    end
    chk("t036_hold_q", int'(CntQ), 1);
    Start = 1'b1;
    step();
    Start = 1'b0;
    wait_idle("t036_timeout", 50);
    chk("t036_final_q", int'(CntQ), 5);

    // async reset in the middle of a run
    start_run(1'b0, 8'd10, 4'd2);
    for (int k = 0; k < 6; k++) step();
    chk("t038_busy_before", int'(Busy), 1);
    #2 Clr = 1'b0;
    #1 check_reset_outputs("t038_async");
    #3 Clr = 1'b1;
    for (int k = 0; k < 10; k++) step();
    chk("t038_no_restart", int'(State), 0);

    step(); step();
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have ports: Clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: Clr  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: Start  in  1  begin a run in IDLE; resume a run in HOLD.
REQ-004 SHALL have ports: Stop  in  1  pause in RUN; abort in HOLD, CLEAR or DONE.
REQ-005 SHALL have ports: Mode  in  1  0 = one-shot, 1 = periodic (auto-restart).
REQ-006 SHALL have ports: Limit  in  8  terminal count, unsigned.
REQ-007 SHALL have ports: Presc  in  4  prescale; one count tick every Presc+1 cycles.
REQ-008 SHALL have ports: CntQ  in  8  current value of the external 8-bit counter being sequenced.
REQ-009 SHALL have ports: CntEn  out  1  count enable to the counter; increments it by 1 on the edge where CntEn=1.
REQ-010 SHALL have ports: CntClr  out  1  active-low clear to the counter.
REQ-011 SHALL have ports: Busy  out  1  high in every state except IDLE.
REQ-012 SHALL have ports: Done  out  1  one-cycle terminal pulse.
REQ-013 SHALL have ports: State  out  3  encoded state: IDLE=000, CLEAR=001, RUN=010, HOLD=011, DONE=100.

Function
REQ-014 SHALL latch Mode, Limit and Presc on the IDLE->CLEAR transition, and SHALL ignore later changes to them until the next IDLE exit.
REQ-015 IDLE: Start=1 and Stop=0 -> CLEAR; otherwise remain in IDLE.
REQ-016 CLEAR: CntClr SHALL be 0 for exactly this one cycle; the prescale counter SHALL be zeroed; next state RUN, or IDLE if Stop=1.
REQ-017 RUN: the 4-bit prescale counter SHALL advance 0..Presc and then wrap to 0.
REQ-018 RUN: CntEn SHALL be 1 only when the prescale counter equals Presc and CntQ != Limit.
REQ-019 RUN: CntQ == Limit -> DONE, and CntEn SHALL be 0 in that cycle.
REQ-020 RUN: Stop=1 -> HOLD, taking precedence over terminal detection; CntEn SHALL be 0 in that cycle.
REQ-021 HOLD: CntEn SHALL be 0 and the prescale counter SHALL be frozen; Stop=1 -> IDLE; Start=1 and Stop=0 -> RUN, resuming with the frozen prescale value.
REQ-022 DONE: Done SHALL be 1 for this single cycle; Stop=1 -> IDLE; otherwise Mode=1 -> CLEAR and Mode=0 -> IDLE.
REQ-023 Start and Stop asserted together SHALL always be treated as Stop.
REQ-024 Start SHALL be ignored in CLEAR, RUN and DONE.
REQ-025 Latency: DONE SHALL be entered exactly Limit*(Presc+1)+2 cycles after CLEAR is entered, with no Stop in between.
REQ-026 Limit=0: RUN SHALL detect terminal in its first cycle and emit no CntEn pulse.
REQ-027 Limit=255 SHALL complete without counter wrap, because CntEn is suppressed at CntQ == Limit.
REQ-028 CntEn, CntClr, Done and Busy SHALL be decoded only from registered state, the prescale counter, the latched Limit and CntQ, and SHALL be glitch-free with respect to Start and Stop.
REQ-029 Outside CLEAR, CntClr SHALL be 1; outside RUN, CntEn SHALL be 0.

Reset
REQ-030 Clr=0 SHALL asynchronously force: State=IDLE, prescale counter=0, latched Limit/Presc/Mode=0, CntEn=0, CntClr=1, Busy=0, Done=0.
REQ-031 Reset asserted mid-run SHALL abandon the run with no Done pulse.
REQ-032 After Clr is released, the block SHALL require a fresh Start.

Verification
REQ-033 One-shot, Limit=3, Presc=0 -> CntClr low 1 cycle, three consecutive CntEn pulses, Done 5 cycles after CLEAR, then IDLE with CntQ=3.
REQ-034 Presc=1, Limit=3 -> CntEn pulses every 2nd cycle; Done 8 cycles after CLEAR.
REQ-035 Periodic, Limit=2, Presc=0 -> Done every 5 cycles (DONE->CLEAR->RUN) until Stop; Stop in DONE -> IDLE.
REQ-036 Stop in RUN at CntQ=1, hold 4 cycles, then Start -> no CntEn while held; run resumes and completes with CntQ=Limit and exactly Limit CntEn pulses in total.
REQ-037 Limit=0 -> zero CntEn pulses and Done 2 cycles after CLEAR; Start and Stop asserted together in IDLE -> stays IDLE.
REQ-038 Clr=0 asserted mid-RUN, asynchronously between edges -> outputs reach reset values immediately; no Done pulse; no restart until Start.
